// File: rtl/layer_mac_sequencer.sv
// Time-multiplexed sequencer for one fully-connected layer.
// Streams input/weight pairs through one external multiplier and one external
// adder, folds in the bias, applies an optional ReLU and writes one result per
// node. All floating-point arithmetic lives outside this block.
module layer_mac_sequencer #(
    parameter int unsigned NUM_IN    = 15,
    parameter int unsigned NUM_NODES = 32,
    parameter int unsigned IN_AW     = 4,
    parameter int unsigned W_AW      = 10,
    parameter int unsigned N_AW      = 5,
    parameter int unsigned RELU      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IN_AW-1:0] in_addr,
    input  logic [31:0]      in_data,
    output logic [W_AW-1:0]  w_addr,
    input  logic [31:0]      w_data,
    output logic [31:0]      mult_x,
    output logic [31:0]      mult_y,
    input  logic [31:0]      mult_z,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_out,
    output logic [N_AW-1:0]  out_addr,
    output logic [31:0]      out_data,
    output logic             out_valid
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StBias,
        StFin,
        StDone
    } state_e;

    localparam logic [IN_AW-1:0] K_LAST    = IN_AW'(NUM_IN - 1);
    localparam logic [N_AW-1:0]  NODE_LAST = N_AW'(NUM_NODES - 1);
    localparam bit               RELU_ON   = (RELU != 0);

    state_e            state_q, state_d;
    logic [IN_AW-1:0]  k_q, k_d;
    logic [N_AW-1:0]   node_q, node_d;
    logic [W_AW-1:0]   wcnt_q, wcnt_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [N_AW-1:0]   out_addr_q, out_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       relu_val;

    // State, counters, accumulator and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= '0;
            node_q      <= '0;
            wcnt_q      <= '0;
            acc_q       <= 32'h0;
            out_data_q  <= 32'h0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            node_q      <= node_d;
            wcnt_q      <= wcnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Sign-bit clamp; -0.0 also maps to +0.
    assign relu_val = (RELU_ON && add_out[31]) ? 32'h0 : add_out;

    // Next-state, counter updates and adder operand steering.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        node_d      = node_q;
        wcnt_d      = wcnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = 1'b0;
        add_a       = 32'h0;
        add_b       = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    node_d  = '0;
                    k_d     = '0;
                    wcnt_d  = '0;
                    acc_d   = 32'h0;
                end
            end

            StRun: begin
                wcnt_d = wcnt_q + 1'b1;
                // Product of term k-1 arrives this cycle; term 0 has none yet.
                if (k_q != '0) begin
                    add_a = acc_q;
                    add_b = mult_z;
                    acc_d = add_out;
                end
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = StBias;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            StBias: begin
                // Fold in the last product while the bias address is issued.
                wcnt_d  = wcnt_q + 1'b1;
                add_a   = acc_q;
                add_b   = mult_z;
                acc_d   = add_out;
                state_d = StFin;
            end

            StFin: begin
                add_a       = acc_q;
                add_b       = w_data;
                out_data_d  = relu_val;
                out_addr_d  = node_q;
                out_valid_d = 1'b1;
                acc_d       = 32'h0;
                k_d         = '0;
                if (node_q == NODE_LAST) begin
                    wcnt_d  = '0;
                    state_d = StDone;
                end else begin
                    node_d  = node_q + 1'b1;
                    state_d = StRun;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status, address and multiplier operand outputs.
    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        in_addr   = k_q;
        w_addr    = wcnt_q;
        mult_x    = in_data;
        mult_y    = w_data;
        out_addr  = out_addr_q;
        out_data  = out_data_q;
        out_valid = out_valid_q;
    end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Bench for layer_mac_sequencer: two instances (ReLU on / off) share stimulus,
// each with its own memories and behavioural float multiplier/adder.
module tb_layer_mac_sequencer;

    localparam int unsigned NI  = 4;
    localparam int unsigned NN  = 2;
    localparam int unsigned IAW = 2;
    localparam int unsigned WAW = 4;
    localparam int unsigned NAW = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t_acc = 0;
    int done_cnt = 0;
    int back2back = 0;
    logic prev_valid = 1'b0;

    logic [31:0] in_mem [NI];
    logic [31:0] w_mem  [16];

    logic [31:0]    qa_data[$];
    logic [NAW-1:0] qa_addr[$];
    int             qa_cyc[$];
    logic [31:0]    qb_data[$];

    // ---------------- float helpers (behavioural external units) ----------
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        int e;
        if (f[30:23] == 8'h0) begin
            d = {f[31], 63'b0};
        end else begin
            e = int'(f[30:23]) + 896;
            d = {f[31], e[10:0], f[22:0], 29'b0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'h0 || e <= 0) return {d[63], 31'b0};
        if (e >= 255) return {d[63], 8'hFF, 23'b0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rand_f();
        int e;
        logic [31:0] f;
        e = 125 + int'($urandom_range(0, 4));
        f = {1'($urandom_range(0, 1)), e[7:0], 3'($urandom_range(0, 7)), 20'b0};
        return f;
    endfunction

    // Reference: sum of products in term order, plus bias, optional clamp.
    function automatic logic [31:0] model(input int n, input bit relu);
        logic [31:0] acc;
        logic [31:0] s;
        acc = 32'h0;
        for (int k = 0; k < NI; k++) begin
            acc = fadd(acc, fmul(in_mem[k], w_mem[n * (NI + 1) + k]));
        end
        s = fadd(acc, w_mem[n * (NI + 1) + NI]);
        return (relu && s[31]) ? 32'h0 : s;
    endfunction

    // ---------------- DUT A (RELU=1) ----------------
    logic           busy_a, done_a, ovalid_a;
    logic [IAW-1:0] in_addr_a;
    logic [WAW-1:0] w_addr_a;
    logic [NAW-1:0] oaddr_a;
    logic [31:0]    in_data_a, w_data_a, mx_a, my_a, mz_a, aa_a, ab_a, ao_a, odata_a;

    layer_mac_sequencer #(
        .NUM_IN(NI), .NUM_NODES(NN), .IN_AW(IAW), .W_AW(WAW), .N_AW(NAW), .RELU(1)
    ) u_relu (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a), .done(done_a),
        .in_addr(in_addr_a), .in_data(in_data_a), .w_addr(w_addr_a), .w_data(w_data_a),
        .mult_x(mx_a), .mult_y(my_a), .mult_z(mz_a),
        .add_a(aa_a), .add_b(ab_a), .add_out(ao_a),
        .out_addr(oaddr_a), .out_data(odata_a), .out_valid(ovalid_a)
    );

    assign mz_a = fmul(mx_a, my_a);
    assign ao_a = fadd(aa_a, ab_a);

    // ---------------- DUT B (RELU=0) ----------------
    logic           busy_b, done_b, ovalid_b;
    logic [IAW-1:0] in_addr_b;
    logic [WAW-1:0] w_addr_b;
    logic [NAW-1:0] oaddr_b;
    logic [31:0]    in_data_b, w_data_b, mx_b, my_b, mz_b, aa_b, ab_b, ao_b, odata_b;

    layer_mac_sequencer #(
        .NUM_IN(NI), .NUM_NODES(NN), .IN_AW(IAW), .W_AW(WAW), .N_AW(NAW), .RELU(0)
    ) u_raw (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_b), .done(done_b),
        .in_addr(in_addr_b), .in_data(in_data_b), .w_addr(w_addr_b), .w_data(w_data_b),
        .mult_x(mx_b), .mult_y(my_b), .mult_z(mz_b),
        .add_a(aa_b), .add_b(ab_b), .add_out(ao_b),
        .out_addr(oaddr_b), .out_data(odata_b), .out_valid(ovalid_b)
    );

    assign mz_b = fmul(mx_b, my_b);
    assign ao_b = fadd(aa_b, ab_b);

    // Synchronous memories with one-cycle read latency.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        in_data_a <= in_mem[in_addr_a];
        w_data_a  <= w_mem[w_addr_a];
        in_data_b <= in_mem[in_addr_b];
        w_data_b  <= w_mem[w_addr_b];
    end

    // Strobe collector.
    always @(negedge clk) begin
        if (ovalid_a) begin
            qa_data.push_back(odata_a);
            qa_addr.push_back(oaddr_a);
            qa_cyc.push_back(cyc);
        end
        if (ovalid_b) qb_data.push_back(odata_b);
        if (ovalid_a && prev_valid) back2back = back2back + 1;
        prev_valid = ovalid_a;
        if (done_a) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        qa_data.delete();
        qa_addr.delete();
        qa_cyc.delete();
        qb_data.delete();
    endtask

    // Runs one layer; optionally checks the address trace and pokes start mid-run.
    task automatic run_layer(input bit trace, input bit poke, output int done_rel);
        clear_q();
        done_rel = -1;
        @(negedge clk); #1;
        chk("idle before start", {31'b0, busy_a}, 32'd0);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        t_acc = cyc;
        chk("busy after accept", {31'b0, busy_a}, 32'd1);
        for (int c = 1; c <= 60; c++) begin
            if (trace) begin
                if (c <= 5) chk("w_addr node0", 32'(w_addr_a), 32'(c - 1));
                if (c >= 7 && c <= 11) chk("w_addr node1", 32'(w_addr_a), 32'(c - 2));
                if (c <= 4) chk("in_addr node0", 32'(in_addr_a), 32'(c - 1));
                if (c >= 7 && c <= 10) chk("in_addr node1", 32'(in_addr_a), 32'(c - 7));
            end
            if (done_a) begin
                done_rel = c;
                break;
            end
            start = poke && (c == 3);
            @(negedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic verify(input string tag);
        chk({tag, " strobes"}, 32'(qa_data.size()), NN);
        chk({tag, " raw strobes"}, 32'(qb_data.size()), NN);
        for (int n = 0; n < NN && n < qa_data.size() && n < qb_data.size(); n++) begin
            chk({tag, " addr"}, 32'(qa_addr[n]), 32'(n));
            chk({tag, " relu data"}, qa_data[n], model(n, 1'b1));
            chk({tag, " raw data"}, qb_data[n], model(n, 1'b0));
            chk({tag, " strobe cycle"}, 32'(qa_cyc[n] - t_acc + 1), 32'((n + 1) * (NI + 2) + 1));
        end
    endtask

    task automatic fill_const(input logic [31:0] x, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] b);
        for (int k = 0; k < NI; k++) in_mem[k] = x;
        for (int i = 0; i < 16; i++) w_mem[i] = 32'h0;
        for (int k = 0; k < NI; k++) begin
            w_mem[k]          = w0;
            w_mem[NI + 1 + k] = w1;
        end
        w_mem[NI]          = b;
        w_mem[2 * NI + 1]  = b;
    endtask

    int d;
    int dc_before;

    initial begin
        fill_const(32'h3F800000, 32'h3F000000, 32'h3F000000, 32'h3E800000);
        repeat (2) @(negedge clk);
        #1;
        chk("rst busy", {31'b0, busy_a}, 32'd0);
        chk("rst done", {31'b0, done_a}, 32'd0);
        chk("rst out_valid", {31'b0, ovalid_a}, 32'd0);
        chk("rst out_data", odata_a, 32'h0);
        chk("rst out_addr", 32'(oaddr_a), 32'd0);
        chk("rst in_addr", 32'(in_addr_a), 32'd0);
        chk("rst w_addr", 32'(w_addr_a), 32'd0);
        chk("rst add_a", aa_a, 32'h0);
        chk("rst add_b", ab_a, 32'h0);
        rst_n = 1'b1;

        // All-positive layer with address trace.
        run_layer(1'b1, 1'b0, d);
        chk("done latency basic", 32'(d), 32'd13);
        #0;
        verify("basic");
        if (qa_data.size() == NN) begin
            chk("basic node0 const", qa_data[0], 32'h40100000);
            chk("basic node1 const", qa_data[1], 32'h40100000);
        end
        chk("busy in done", {31'b0, busy_a}, 32'd1);

        // Negative node 1, back-to-back start right after done.
        fill_const(32'h3F800000, 32'h3F000000, 32'hBF000000, 32'h3E800000);
        run_layer(1'b0, 1'b0, d);
        chk("done latency b2b", 32'(d), 32'd13);
        verify("negative");
        if (qa_data.size() == NN && qb_data.size() == NN) begin
            chk("neg node0 const", qa_data[0], 32'h40100000);
            chk("neg node1 relu const", qa_data[1], 32'h00000000);
            chk("neg node1 raw const", qb_data[1], 32'hBFE00000);
        end

        // Start pulsed while busy must be ignored.
        run_layer(1'b0, 1'b1, d);
        chk("done latency poke", 32'(d), 32'd13);
        verify("poke");

        // Reset during node 1 RUN.
        clear_q();
        dc_before = done_cnt;
        @(negedge clk); #1;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", {31'b0, busy_a}, 32'd0);
        chk("midrst out_valid", {31'b0, ovalid_a}, 32'd0);
        chk("midrst done", {31'b0, done_a}, 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("midrst no done", 32'(done_cnt - dc_before), 32'd0);
        chk("midrst strobes", 32'(qa_data.size()), 32'd1);
        run_layer(1'b1, 1'b0, d);
        chk("done latency post-rst", 32'(d), 32'd13);
        verify("post-rst");

        // Zero sum with -0.0 bias.
        fill_const(32'h3F800000, 32'h00000000, 32'h00000000, 32'h80000000);
        for (int k = 0; k < NI; k++) in_mem[k] = rand_f();
        run_layer(1'b0, 1'b0, d);
        verify("zero");
        if (qa_data.size() == NN) chk("zero node0 const", qa_data[0], 32'h0);

        // Randomized layers.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NI; k++) in_mem[k] = rand_f();
            for (int i = 0; i < 16; i++) w_mem[i] = rand_f();
            run_layer(1'b0, 1'b0, d);
            chk("done latency rand", 32'(d), 32'd13);
            verify("rand");
        end

        chk("out_valid back-to-back", 32'(back2back), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
